// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes (also decoded by the MDU), issue-controller state encoding, watchdog limit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5,
      MDU_MFHI  = 3'd6,
      MDU_MFLO  = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_READ = 2'd2
   } ctrl_state_e;

   localparam logic [4:0] WD_LIMIT = 5'd31;

   function automatic logic is_compute(input logic [2:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   function automatic logic is_move_to(input logic [2:0] op);
      return (op == MDU_MTHI) || (op == MDU_MTLO);
   endfunction

endpackage

// File: rtl/mdu_issue_ctrl.sv
// Issue/interlock control between the E stage and the multiply/divide unit: compute and MT ops issue in
// the request cycle, MFHI/MFLO cost one stall plus one read cycle; E is stalled while an MDU op is running.
module mdu_issue_ctrl
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   input  logic        flush,
   output logic        stall,
   output logic        mdu_start,
   output logic [2:0]  mdu_ctrl,
   output logic [31:0] mdu_srca,
   output logic [31:0] mdu_srcb,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        wd_err
);

   ctrl_state_e state_q, state_d;
   logic        first_q, first_d;
   logic [4:0]  wd_cnt_q, wd_cnt_d;
   logic [4:0]  wd_nxt;
   logic        wd_err_q, wd_trip;
   logic [31:0] rd_data_q;
   logic        req, done, accept;
   logic        stall_c, start_c, rd_load;

   assign req    = req_valid & ~flush;
   assign wd_nxt = wd_cnt_q + 5'd1;
   // The MDU's busy flag lags the start pulse by a cycle, so the first RUN cycle is never "done".
   assign done   = (state_q == ST_RUN) && !first_q && !mdu_busy;
   assign accept = (state_q == ST_IDLE) || done;

   always_comb begin
      state_d  = state_q;
      first_d  = 1'b0;
      wd_cnt_d = wd_cnt_q;
      wd_trip  = 1'b0;
      stall_c  = 1'b0;
      start_c  = 1'b0;
      rd_load  = 1'b0;

      case (state_q)
         ST_READ: state_d = ST_IDLE;
         ST_RUN: begin
            if (!done) begin
               stall_c  = req;
               wd_cnt_d = wd_nxt;
               if (wd_nxt == WD_LIMIT) begin
                  wd_trip = 1'b1;
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: ;
      endcase

      // A completing RUN behaves as IDLE in the same cycle so a waiting request pays no bubble.
      if (accept && req) begin
         if (is_compute(req_op)) begin
            start_c  = 1'b1;
            first_d  = 1'b1;
            wd_cnt_d = '0;
            state_d  = ST_RUN;
         end else if (is_move_to(req_op)) begin
            start_c = 1'b1;
         end else begin
            stall_c = 1'b1;
            rd_load = 1'b1;
            state_d = ST_READ;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         first_q   <= 1'b0;
         wd_cnt_q  <= '0;
         wd_err_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         wd_cnt_q <= wd_cnt_d;
         wd_err_q <= wd_err_q | wd_trip;
         if (rd_load) begin
            rd_data_q <= (req_op == MDU_MFHI) ? mdu_hi : mdu_lo;
         end
      end
   end

   // Gated by reset so a request held on the inputs cannot stall or issue while reset is low.
   assign stall     = stall_c & reset;
   assign mdu_start = start_c & reset;
   assign mdu_ctrl  = req_op;
   assign mdu_srca  = req_a;
   assign mdu_srcb  = req_b;
   assign rd_data   = rd_data_q;
   assign rd_valid  = (state_q == ST_READ);
   assign wd_err    = wd_err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Bench for mdu_issue_ctrl: behavioural MDU model, directed instruction stream, scoreboard on issue and read-back.
module tb_mdu_issue_ctrl;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a, req_b;
   logic        flush;
   logic        stall, mdu_start;
   logic [2:0]  mdu_ctrl;
   logic [31:0] mdu_srca, mdu_srcb;
   logic        mdu_busy;
   logic [31:0] mdu_hi, mdu_lo;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wd_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mdu_issue_ctrl dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
      .mdu_start(mdu_start), .mdu_ctrl(mdu_ctrl), .mdu_srca(mdu_srca), .mdu_srcb(mdu_srcb),
      .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
      .rd_data(rd_data), .rd_valid(rd_valid), .wd_err(wd_err)
   );

   // ---------------- behavioural MDU: busy rises one cycle after start ----------------
   logic        m_pend, m_busy_r, force_busy;
   logic [3:0]  m_cnt;
   logic [2:0]  m_op;
   logic [31:0] m_a, m_b;

   function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      r = '0;
      case (op)
         MDU_MULT:  r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
         MDU_MULTU: r = {32'd0, a} * {32'd0, b};
         MDU_DIV:   r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
         MDU_DIVU:  r = {a % b, a / b};
         default:   r = '0;
      endcase
      return r;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_pend <= 1'b0; m_busy_r <= 1'b0; m_cnt <= '0; m_op <= '0;
         m_a <= '0; m_b <= '0; mdu_hi <= '0; mdu_lo <= '0;
      end else begin
         if (m_pend) begin
            m_pend   <= 1'b0;
            m_busy_r <= 1'b1;
            m_cnt    <= (m_op == MDU_DIV || m_op == MDU_DIVU) ? 4'd8 : 4'd4;
         end else if (m_busy_r) begin
            if (m_cnt == 4'd1) begin
               m_busy_r <= 1'b0;
               {mdu_hi, mdu_lo} <= calc(m_op, m_a, m_b);
            end else begin
               m_cnt <= m_cnt - 4'd1;
            end
         end
         if (mdu_start) begin
            if (mdu_ctrl == MDU_MTHI) mdu_hi <= mdu_srca;
            else if (mdu_ctrl == MDU_MTLO) mdu_lo <= mdu_srca;
            else begin
               m_pend <= 1'b1; m_op <= mdu_ctrl; m_a <= mdu_srca; m_b <= mdu_srcb;
            end
         end
      end
   end

   assign mdu_busy = m_busy_r | force_busy;

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        chk_hl;
      logic [31:0] hi;
      logic [31:0] lo;
   } iss_t;

   iss_t        iss_q[$];
   logic [31:0] rd_q[$];
   iss_t        e_iss;
   logic [31:0] e_rd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (mdu_start) begin
            if (iss_q.size() == 0) chk("unexpected_mdu_start", 32'(mdu_start), 32'd0);
            else begin
               e_iss = iss_q.pop_front();
               chk("mdu_ctrl", 32'(mdu_ctrl), 32'(e_iss.op));
               chk("mdu_srca", mdu_srca, e_iss.a);
               chk("mdu_srcb", mdu_srcb, e_iss.b);
               if (e_iss.chk_hl) begin
                  chk("hi_before_issue", mdu_hi, e_iss.hi);
                  chk("lo_before_issue", mdu_lo, e_iss.lo);
               end
            end
         end
         if (rd_valid) begin
            if (rd_q.size() == 0) chk("unexpected_rd_valid", 32'(rd_valid), 32'd0);
            else begin
               e_rd = rd_q.pop_front();
               chk("rd_data", rd_data, e_rd);
            end
         end
      end
   end

   // ---------------- driver ----------------
   // Presents one instruction, holds it while stall=1, and checks the number of stall cycles.
   task automatic run_instr(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int exp_stall, input logic [31:0] exp_rd,
                            input logic chk_hl, input logic [31:0] ehi, input logic [31:0] elo,
                            input string nm);
      int   n;
      logic s;
      iss_t e;
      n = 0;
      if (op == MDU_MFHI || op == MDU_MFLO) rd_q.push_back(exp_rd);
      else begin
         e.op = op; e.a = a; e.b = b; e.chk_hl = chk_hl; e.hi = ehi; e.lo = elo;
         iss_q.push_back(e);
      end
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         s = stall;
         @(posedge clk);
         #1;
         if (!s) break;
         n++;
      end
      req_valid = 1'b0;
      chk({nm, "_stall_cycles"}, 32'(n), 32'(exp_stall));
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      flush = 1'b0; force_busy = 1'b0;
      #12;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_mdu_start", 32'(mdu_start), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_wd_err", 32'(wd_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc(1);

      // MULT -1 x 2, then MFLO/MFHI
      run_instr(MDU_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0, 0, 0, 0, "mult");
      run_instr(MDU_MFLO, 0, 0, 6, 32'hFFFF_FFFE, 0, 0, 0, "mflo_after_mult");
      run_instr(MDU_MFHI, 0, 0, 1, 32'hFFFF_FFFF, 0, 0, 0, "mfhi_after_mult");

      // DIVU 7/2 immediately followed by MULT 3x5
      run_instr(MDU_DIVU, 32'd7, 32'd2, 0, 0, 0, 0, 0, "divu");
      run_instr(MDU_MULT, 32'd3, 32'd5, 9, 0, 1, 32'd1, 32'd3, "mult_behind_divu");
      run_instr(MDU_MFLO, 0, 0, 6, 32'd15, 0, 0, 0, "mflo_3x5");
      run_instr(MDU_MFHI, 0, 0, 1, 32'd0, 0, 0, 0, "mfhi_3x5");

      // MTLO then MFLO
      run_instr(MDU_MTLO, 32'h0000_1234, 32'h0, 0, 0, 0, 0, 0, "mtlo");
      run_instr(MDU_MFLO, 0, 0, 1, 32'h0000_1234, 0, 0, 0, "mflo_after_mtlo");

      // flushed MFHI during RUN, then non-MDU cycle, then MTHI waits for completion
      run_instr(MDU_MULT, 32'h10, 32'h20, 0, 0, 0, 0, 0, "mult_flush");
      req_valid = 1'b1; req_op = MDU_MFHI; flush = 1'b1;
      @(negedge clk);
      chk("flushed_mfhi_stall", 32'(stall), 32'd0);
      chk("flushed_mfhi_rd_valid", 32'(rd_valid), 32'd0);
      cyc(1);
      req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("non_mdu_stall", 32'(stall), 32'd0);
      cyc(1);
      run_instr(MDU_MTHI, 32'hCAFE_F00D, 32'h0, 3, 0, 0, 0, 0, "mthi_wait_run");
      run_instr(MDU_MFHI, 0, 0, 1, 32'hCAFE_F00D, 0, 0, 0, "mfhi_after_mthi");
      run_instr(MDU_MFLO, 0, 0, 1, 32'h0000_0200, 0, 0, 0, "mflo_0x10x0x20");

      // watchdog: MDU busy stuck high for 40 cycles
      run_instr(MDU_MULT, 32'd9, 32'd9, 0, 0, 0, 0, 0, "mult_wd");
      force_busy = 1'b1;
      run_instr(MDU_MULTU, 32'd2, 32'd3, 31, 0, 0, 0, 0, "multu_behind_wd");
      chk("wd_err_set", 32'(wd_err), 32'd1);
      cyc(8);
      force_busy = 1'b0;
      cyc(10);
      chk("wd_err_sticky", 32'(wd_err), 32'd1);
      run_instr(MDU_MFLO, 0, 0, 1, 32'd6, 0, 0, 0, "mflo_after_wd");
      chk("wd_err_still_set", 32'(wd_err), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("wd_err_cleared_by_reset", 32'(wd_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc(1);

      // reset two cycles into a DIV with MFLO waiting
      run_instr(MDU_DIV, 32'd100, 32'd7, 0, 0, 0, 0, 0, "div_reset");
      req_valid = 1'b1; req_op = MDU_MFLO; req_a = '0; req_b = '0;
      @(negedge clk);
      chk("div_wait_stall_c1", 32'(stall), 32'd1);
      cyc(1);
      @(negedge clk);
      chk("div_wait_stall_c2", 32'(stall), 32'd1);
      reset = 1'b0;
      #1;
      chk("async_rst_stall", 32'(stall), 32'd0);
      chk("async_rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("async_rst_mdu_start", 32'(mdu_start), 32'd0);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      cyc(1);
      run_instr(MDU_MFLO, 0, 0, 1, 32'd0, 0, 0, 0, "mflo_after_reset");
      run_instr(MDU_MTHI, 32'hA5A5_A5A5, 32'h0, 0, 0, 0, 0, 0, "mthi_final");
      run_instr(MDU_MFHI, 0, 0, 1, 32'hA5A5_A5A5, 0, 0, 0, "mfhi_final");
      cyc(3);

      chk("issue_queue_drained", 32'(iss_q.size()), 32'd0);
      chk("read_queue_drained", 32'(rd_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
